// File: rtl/divider_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
// Holds the per-stage control record, the stage-count function and an all-ones constant.
package divider_pkg;

    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

    // Control part of the stage record. The datapath part (p, dvd_shift, divisor)
    // is width-parameterised and therefore lives in the stage module ports.
    typedef struct packed {
        logic valid;
        logic sign_q;
        logic sign_r;
        logic zero;
    } stage_ctrl_t;

    function automatic int div_nstages(input int width, input int steps);
        return (width + steps - 1) / steps;
    endfunction

endpackage

// File: rtl/div_stage.sv
// One registered pipeline stage of the restoring divider: NBITS unrolled divide steps
// followed by a pause-gated register. KEEP_REM=0 drops the partial-remainder register.
module div_stage
    import divider_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NBITS    = 2,
    parameter bit KEEP_REM = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              pause,
    input  stage_ctrl_t       ctrl_i,
    input  logic [WIDTH-1:0]  p_i,
    input  logic [WIDTH-1:0]  dvd_i,
    input  logic [WIDTH-1:0]  dvs_i,
    output stage_ctrl_t       ctrl_o,
    output logic [WIDTH-1:0]  p_o,
    output logic [WIDTH-1:0]  dvd_o
);

    logic [WIDTH-1:0] p_step   [NBITS+1];
    logic [WIDTH-1:0] dvd_step [NBITS+1];

    assign p_step[0]   = p_i;
    assign dvd_step[0] = dvd_i;

    // dvd_step shifts dividend bits out of the top while quotient bits enter at the bottom.
    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_step
            logic [WIDTH:0]   trial;
            logic [WIDTH-1:0] diff;
            logic             ge;

            assign trial = {p_step[gi], dvd_step[gi][WIDTH-1]};
            assign ge    = (trial >= {1'b0, dvs_i});
            // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
            assign diff  = trial[WIDTH-1:0] - dvs_i;
            assign p_step[gi+1]   = ge ? diff : trial[WIDTH-1:0];
            assign dvd_step[gi+1] = {dvd_step[gi][WIDTH-2:0], ge};
        end
    endgenerate

    stage_ctrl_t      ctrl_q;
    logic [WIDTH-1:0] dvd_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ctrl_q <= '0;
            dvd_q  <= '0;
        end else if (!pause) begin
            ctrl_q <= ctrl_i;
            dvd_q  <= dvd_step[NBITS];
        end
    end

    assign ctrl_o = ctrl_q;
    assign dvd_o  = dvd_q;

    generate
        if (KEEP_REM) begin : g_rem
            logic [WIDTH-1:0] p_q;
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    p_q <= '0;
                end else if (!pause) begin
                    p_q <= p_step[NBITS];
                end
            end
            assign p_o = p_q;
        end else begin : g_no_rem
            assign p_o = '0;
        end
    endgenerate

endmodule

// File: rtl/pipelined_divider.sv
// Fully pipelined restoring divider, one operation per cycle, optional signed mode.
// Define PIPELINED_DIVIDER_REMAINDER_EN to carry the remainder to remainder_out (else tied 0).
module pipelined_divider
    import divider_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int STEPS_PER_STAGE = 2,
    parameter int SIGNED          = 0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    input  logic             data_valid_in,
    input  logic             pause,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_zero_out,
    output logic             data_valid_out,
    output logic             busy_out
);

    localparam int NSTAGES   = div_nstages(WIDTH, STEPS_PER_STAGE);
    localparam int LAST_BITS = WIDTH - (NSTAGES - 1) * STEPS_PER_STAGE;
    localparam int DVS_REGS  = (NSTAGES > 1) ? NSTAGES - 1 : 1;
`ifdef PIPELINED_DIVIDER_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic             dvd_neg, dvs_neg, dvs_zero;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    stage_ctrl_t      ctrl_c [NSTAGES+1];
    logic [WIDTH-1:0] p_c    [NSTAGES+1];
    logic [WIDTH-1:0] dvd_c  [NSTAGES+1];
    logic [WIDTH-1:0] dvs_q  [DVS_REGS];

    assign dvs_zero = (divisor_in == '0);
    assign dvd_neg  = (SIGNED != 0) && dividend_in[WIDTH-1];
    assign dvs_neg  = (SIGNED != 0) && divisor_in[WIDTH-1];
    // A zero divisor passes the raw dividend through so the final remainder equals it unchanged.
    assign dvd_mag  = (dvd_neg && !dvs_zero) ? (~dividend_in + 1'b1) : dividend_in;
    assign dvs_mag  = dvs_neg ? (~divisor_in + 1'b1) : divisor_in;

    assign ctrl_c[0] = '{valid:  data_valid_in,
                         sign_q: (dvd_neg ^ dvs_neg) && !dvs_zero,
                         sign_r: dvd_neg && !dvs_zero,
                         zero:   dvs_zero};
    assign p_c[0]   = '0;
    assign dvd_c[0] = dvd_mag;

    // Divisor travels alongside the operands; stage gi reads the copy aligned with its inputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DVS_REGS; i++) dvs_q[i] <= '0;
        end else if (!pause) begin
            dvs_q[0] <= dvs_mag;
            for (int i = 1; i < DVS_REGS; i++) dvs_q[i] <= dvs_q[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] dvs_sel;
            if (gi == 0) begin : g_first
                assign dvs_sel = dvs_mag;
            end else begin : g_rest
                assign dvs_sel = dvs_q[gi-1];
            end

            div_stage #(
                .WIDTH    (WIDTH),
                .NBITS    ((gi == NSTAGES - 1) ? LAST_BITS : STEPS_PER_STAGE),
                .KEEP_REM ((gi < NSTAGES - 1) || REM_EN)
            ) u_stage (
                .clk_in   (clk_in),
                .rst_n_in (rst_n_in),
                .pause    (pause),
                .ctrl_i   (ctrl_c[gi]),
                .p_i      (p_c[gi]),
                .dvd_i    (dvd_c[gi]),
                .dvs_i    (dvs_sel),
                .ctrl_o   (ctrl_c[gi+1]),
                .p_o      (p_c[gi+1]),
                .dvd_o    (dvd_c[gi+1])
            );
        end

        if (SIGNED != 0) begin : g_sign
            logic [WIDTH-1:0] quo_q, quo_d;
            logic             zero_q, valid_q;

            always_comb begin
                quo_d = ctrl_c[NSTAGES].sign_q ? (~dvd_c[NSTAGES] + 1'b1) : dvd_c[NSTAGES];
                if (ctrl_c[NSTAGES].zero) quo_d = ALL_ONES[WIDTH-1:0];
            end

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    quo_q   <= '0;
                    zero_q  <= 1'b0;
                    valid_q <= 1'b0;
                end else if (!pause) begin
                    quo_q   <= quo_d;
                    zero_q  <= ctrl_c[NSTAGES].zero;
                    valid_q <= ctrl_c[NSTAGES].valid;
                end
            end

            assign quotient_out   = quo_q;
            assign div_zero_out   = zero_q;
            assign data_valid_out = valid_q;

`ifdef PIPELINED_DIVIDER_REMAINDER_EN
            logic [WIDTH-1:0] rem_q, rem_d;
            assign rem_d = ctrl_c[NSTAGES].sign_r ? (~p_c[NSTAGES] + 1'b1) : p_c[NSTAGES];
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    rem_q <= '0;
                end else if (!pause) begin
                    rem_q <= rem_d;
                end
            end
            assign remainder_out = rem_q;
`else
            assign remainder_out = '0;
`endif
        end else begin : g_unsigned
            assign quotient_out   = dvd_c[NSTAGES];
            assign div_zero_out   = ctrl_c[NSTAGES].zero;
            assign data_valid_out = ctrl_c[NSTAGES].valid;
`ifdef PIPELINED_DIVIDER_REMAINDER_EN
            assign remainder_out  = p_c[NSTAGES];
`else
            assign remainder_out  = '0;
`endif
        end
    endgenerate

    logic busy_any;
    always_comb begin
        busy_any = data_valid_out;
        for (int i = 1; i <= NSTAGES; i++) busy_any = busy_any | ctrl_c[i].valid;
    end
    assign busy_out = busy_any;

endmodule

// File: tb/tb_pipelined_divider.sv
// Directed bench for pipelined_divider: an unsigned and a signed instance, vector table,
// back-to-back stream with a pause, and reset with operations in flight.
module tb_pipelined_divider;

`ifdef PIPELINED_DIVIDER_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] u_dvd = '0, u_dvs = '0, s_dvd = '0, s_dvs = '0;
    logic        u_vin = 1'b0, s_vin = 1'b0;
    logic [15:0] u_q, u_r, s_q, s_r;
    logic        u_z, u_v, u_busy, s_z, s_v, s_busy;

    always #5 clk = ~clk;

    pipelined_divider #(.WIDTH(16), .STEPS_PER_STAGE(2), .SIGNED(0)) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .dividend_in(u_dvd), .divisor_in(u_dvs),
        .data_valid_in(u_vin), .pause(pause), .quotient_out(u_q), .remainder_out(u_r),
        .div_zero_out(u_z), .data_valid_out(u_v), .busy_out(u_busy));

    pipelined_divider #(.WIDTH(16), .STEPS_PER_STAGE(2), .SIGNED(1)) u_sdut (
        .clk_in(clk), .rst_n_in(rst_n), .dividend_in(s_dvd), .divisor_in(s_dvs),
        .data_valid_in(s_vin), .pause(pause), .quotient_out(s_q), .remainder_out(s_r),
        .div_zero_out(s_z), .data_valid_out(s_v), .busy_out(s_busy));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    typedef struct {
        bit          sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        bit          z;
    } vec_t;

    task automatic apply(input vec_t v, input int idx);
        int          cnt;
        int          lat;
        logic        vo;
        logic [15:0] exp_r;
        lat   = v.sgn ? 9 : 8;
        exp_r = REM_EN ? v.r : 16'h0000;
        @(negedge clk);
        if (v.sgn) begin s_dvd = v.a; s_dvs = v.b; s_vin = 1'b1; end
        else       begin u_dvd = v.a; u_dvs = v.b; u_vin = 1'b1; end
        @(posedge clk); #1;
        s_vin = 1'b0;
        u_vin = 1'b0;
        cnt = 1;
        vo  = v.sgn ? s_v : u_v;
        while (!vo && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            vo = v.sgn ? s_v : u_v;
        end
        chk($sformatf("vec%0d latency", idx), cnt, lat);
        chk($sformatf("vec%0d quotient", idx), v.sgn ? s_q : u_q, v.q);
        chk($sformatf("vec%0d remainder", idx), v.sgn ? s_r : u_r, exp_r);
        chk($sformatf("vec%0d div_zero", idx), v.sgn ? s_z : u_z, v.z);
        @(posedge clk); #1;
        chk($sformatf("vec%0d valid pulse ends", idx), v.sgn ? s_v : u_v, 1'b0);
    endtask

    // Stream collector: a result is consumed on each advancing edge that presents it.
    logic        collect_en = 1'b0;
    int          got = 0;
    int          adv_cnt = 0;
    int          first_adv = 0;
    logic [15:0] st_q [16];
    logic [15:0] st_r [16];

    always begin
        @(posedge clk); #1;
        if (collect_en && !pause) begin
            adv_cnt++;
            if (u_v) begin
                if (got < 16) begin
                    chk($sformatf("stream%0d quotient", got), u_q, st_q[got]);
                    chk($sformatf("stream%0d remainder", got), u_r, st_r[got]);
                    if (got == 0) first_adv = adv_cnt;
                    else chk($sformatf("stream%0d slot", got), adv_cnt, first_adv + got);
                end
                got++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [14];
    int   seen;

    initial begin
        vecs[0]  = '{0, 16'd1000,  16'd7,     16'd142,   16'd6,     0};
        vecs[1]  = '{0, 16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1};
        vecs[2]  = '{0, 16'd0,     16'd5,     16'd0,     16'd0,     0};
        vecs[3]  = '{0, 16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     0};
        vecs[4]  = '{0, 16'd100,   16'd10,    16'd10,    16'd0,     0};
        vecs[5]  = '{0, 16'd7,     16'd1000,  16'd0,     16'd7,     0};
        vecs[6]  = '{0, 16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     0};
        vecs[7]  = '{0, 16'h8000,  16'd3,     16'h2AAA,  16'd2,     0};
        vecs[8]  = '{1, 16'hFFF9,  16'd2,     16'hFFFD,  16'hFFFF,  0};
        vecs[9]  = '{1, 16'd7,     16'hFFFE,  16'hFFFD,  16'd1,     0};
        vecs[10] = '{1, 16'h8000,  16'hFFFF,  16'h8000,  16'd0,     0};
        vecs[11] = '{1, 16'hFFF9,  16'd0,     16'hFFFF,  16'hFFF9,  1};
        vecs[12] = '{1, 16'd100,   16'hFFF9,  16'hFFF2,  16'd2,     0};
        vecs[13] = '{1, 16'hFF9C,  16'hFFF9,  16'h000E,  16'hFFFE,  0};

        // Reset state: outputs low while reset is held and after release.
        #12;
        chk("reset valid", u_v, 1'b0);
        chk("reset busy", u_busy, 1'b0);
        chk("reset quotient", u_q, 16'h0000);
        chk("reset signed valid", s_v, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-release valid", u_v, 1'b0);
        chk("post-release busy", u_busy | s_busy, 1'b0);

        for (int i = 0; i < 14; i++) apply(vecs[i], i);

        // Back-to-back stream with a 3-cycle pause holding operand 8.
        for (int i = 0; i < 16; i++) begin
            st_q[i] = 16'((i * 97) / (i + 1));
            st_r[i] = REM_EN ? 16'((i * 97) % (i + 1)) : 16'h0000;
        end
        @(negedge clk);
        collect_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            u_dvd = 16'(i * 97);
            u_dvs = 16'(i + 1);
            u_vin = 1'b1;
            if (i == 8) begin
                pause = 1'b1;
                repeat (3) @(negedge clk);
                pause = 1'b0;
            end
        end
        @(negedge clk);
        u_vin = 1'b0;
        for (int k = 0; k < 40 && got < 16; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("stream result count", got, 16);
        collect_en = 1'b0;

        // Reset with five operations in flight.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            u_dvd = 16'(500 + i);
            u_dvs = 16'd3;
            u_vin = 1'b1;
        end
        @(negedge clk);
        u_vin = 1'b0;
        chk("in-flight busy", u_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset valid", u_v, 1'b0);
        chk("async reset busy", u_busy, 1'b0);
        chk("async reset quotient", u_q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (u_v || u_busy) seen = 1;
        end
        chk("no output after reset", seen, 0);

        // Pipe still works after the mid-operation reset.
        apply(vecs[0], 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
